// File: rtl/clk2_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clk2_timer_pkg
// Purpose  : Shared types and defaults for the clk2 tick timer slice.
//            - timer_state_t : FSM state encoding (IDLE / RUN / DONE)
//            - CNT_W_DEF     : default width of the tick counters
//            - is_last_tick  : helper that flags the final tick of a run
// Revision : 1.0 - initial release
// ============================================================================
package clk2_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_t;

    localparam int CNT_W_DEF = 8;

    // True when the remaining count is exactly one. The tick that arrives
    // while this holds is the one that ends the run.
    function automatic logic is_last_tick(input logic [31:0] cnt);
        return (cnt == 32'd1);
    endfunction

endpackage : clk2_timer_pkg
`default_nettype wire

// File: rtl/clk2_tick_timer_rise_detect.sv
`default_nettype none
// ============================================================================
// Module   : rise_detect
// Purpose  : Rising-edge detector for a level that is already synchronous
//            to clk. Produces a one-cycle pulse on the cycle the level
//            first reads high after having been low.
// Ports    : clk   - system clock
//            rst_n - synchronous active-low reset
//            d     - level to watch
//            pulse - d & ~d_delayed (combinational)
// Revision : 1.0 - initial release
// ============================================================================
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic pulse
);

    logic r_d;

    // The delayed copy resets high: if d is already high when reset lifts,
    // that level is treated as old news rather than a fresh edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_d <= 1'b1;
        end else begin
            r_d <= d;
        end
    end

    assign pulse = d & ~r_d;

endmodule : rise_detect
`default_nettype wire

// File: rtl/clk2_tick_timer.sv
`default_nettype none
// ============================================================================
// Module   : clk2_tick_timer
// Purpose  : Consumes the divided clock level clk2, turns each rising edge
//            into a one-cycle tick, and runs a programmable down-count timer
//            measured in ticks with a start/done/ack handshake and optional
//            auto-reload. Ticks seen while running are also counted.
// Ports    : clk         - system clock
//            rst_n       - synchronous active-low reset
//            clk2        - divided clock level, synchronous to clk
//            start       - start request, honoured only in IDLE
//            load_val    - timer length in ticks, latched on accepted start
//            auto_reload - sampled when ack is accepted in DONE
//            ack         - acknowledges done
//            abort       - forces a return to IDLE from any state
//            tick        - clk2 rising edge (combinational)
//            busy        - timer running (registered)
//            done        - timer expired, awaiting ack (registered)
//            count_q     - remaining ticks
//            tick_cnt    - ticks seen in RUN, wraps modulo 2^CNT_W
// Revision : 1.0 - initial release
// ============================================================================
module clk2_tick_timer
    import clk2_timer_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk2,
    input  logic             start,
    input  logic [CNT_W-1:0] load_val,
    input  logic             auto_reload,
    input  logic             ack,
    input  logic             abort,
    output logic             tick,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count_q,
    output logic [CNT_W-1:0] tick_cnt
);

    localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

    timer_state_t     r_state;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_reload;
    logic [CNT_W-1:0] r_tick_cnt;
    logic             w_tick;
    logic             w_last;

    rise_detect u_rise_detect (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (clk2),
        .pulse (w_tick)
    );

    assign w_last = is_last_tick(32'(r_count));

    // Single FSM process. busy/done are written alongside every state
    // transition so they always equal the decode of the state register
    // without an extra combinational layer on the outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_count    <= '0;
            r_reload   <= '0;
            r_tick_cnt <= '0;
        end else if (abort) begin
            // tick_cnt deliberately holds: a tick coinciding with abort is
            // not counted.
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_reload <= load_val;
                        r_count  <= load_val;
                        if (load_val == '0) begin
                            // Zero-length run completes immediately.
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= RUN;
                            r_busy  <= 1'b1;
                        end
                    end
                end

                RUN: begin
                    if (w_tick) begin
                        r_tick_cnt <= r_tick_cnt + c_one;
                        if (w_last) begin
                            r_count <= '0;
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_count <= r_count - c_one;
                        end
                    end
                end

                DONE: begin
                    // Ticks are ignored here; one coinciding with ack is
                    // dropped, and a reload entry is not decremented until
                    // the next tick seen in RUN.
                    if (ack) begin
                        r_done <= 1'b0;
                        if (auto_reload && (r_reload != '0)) begin
                            r_count <= r_reload;
                            r_state <= RUN;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_count <= '0;
                end
            endcase
        end
    end

    assign tick     = w_tick;
    assign busy     = r_busy;
    assign done     = r_done;
    assign count_q  = r_count;
    assign tick_cnt = r_tick_cnt;

endmodule : clk2_tick_timer
`default_nettype wire

// File: tb/tb_clk2_tick_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk2_tick_timer
// Purpose  : Self-checking bench for clk2_tick_timer. Two instances share
//            clk, rst_n, clk2 and the control inputs; the 8-bit instance
//            runs the handshake/reload/abort scenarios, the 4-bit instance
//            (separate start) runs the tick_cnt wrap scenario. Expected
//            values are hand-computed and queued per cycle; a monitor pops
//            and compares them on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk2_tick_timer;

    logic       clk;
    logic       rst_n;
    logic       clk2;
    logic       start;
    logic       start4;
    logic [7:0] load_val;
    logic       auto_reload;
    logic       ack;
    logic       abort;

    logic       tick8, busy8, done8;
    logic [7:0] cnt8, tc8;
    logic       tick4, busy4, done4;
    logic [3:0] cnt4, tc4;

    clk2_tick_timer #(.CNT_W(8)) dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .clk2        (clk2),
        .start       (start),
        .load_val    (load_val),
        .auto_reload (auto_reload),
        .ack         (ack),
        .abort       (abort),
        .tick        (tick8),
        .busy        (busy8),
        .done        (done8),
        .count_q     (cnt8),
        .tick_cnt    (tc8)
    );

    clk2_tick_timer #(.CNT_W(4)) dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .clk2        (clk2),
        .start       (start4),
        .load_val    (load_val[3:0]),
        .auto_reload (auto_reload),
        .ack         (ack),
        .abort       (abort),
        .tick        (tick4),
        .busy        (busy4),
        .done        (done4),
        .count_q     (cnt4),
        .tick_cnt    (tc4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Number of rising clk edges so far.
    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        int         cyc;
        bit         sel4;
        string      nm;
        logic       t, b, d;
        logic [7:0] c, tc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // clk2 pattern: phases 0,1 low, 2,3 high -> tick on phase 2.
    bit ph_on = 1'b0;
    int ph    = 0;

    task automatic drv(input bit st, input bit st4, input logic [7:0] lv,
                       input bit ar, input bit ak, input bit ab);
        if (ph_on) clk2 = ((ph % 4) >= 2);
        start = st; start4 = st4; load_val = lv;
        auto_reload = ar; ack = ak; abort = ab;
    endtask

    task automatic push(input bit s4, input string nm, input bit t, input bit b,
                        input bit d, input logic [7:0] c, input logic [7:0] tc);
        exp_t e;
        e.cyc = cyc_cnt; e.sel4 = s4; e.nm = nm;
        e.t = t; e.b = b; e.d = d; e.c = c; e.tc = tc;
        sb.push_back(e);
    endtask

    task automatic e8(input string nm, input bit t, input bit b, input bit d,
                      input logic [7:0] c, input logic [7:0] tc);
        push(1'b0, nm, t, b, d, c, tc);
    endtask

    task automatic e4(input string nm, input bit t, input bit b, input bit d,
                      input logic [7:0] c, input logic [7:0] tc);
        push(1'b1, nm, t, b, d, c, tc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (ph_on) ph++;
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) begin
            drv(0, 0, 8'd0, 0, 0, 0);
            step();
        end
    endtask

    // Monitor: compare every expectation due in this cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
            automatic exp_t e = sb.pop_front();
            automatic logic [18:0] act;
            automatic logic [18:0] want;
            n_cmp++;
            if (e.sel4)
                act = {tick4, busy4, done4, {4'd0, cnt4}, {4'd0, tc4}};
            else
                act = {tick8, busy8, done8, cnt8, tc8};
            want = {e.t, e.b, e.d, e.c, e.tc};
            if (e.cyc != cyc_cnt) begin
                n_bad++;
                $display("FAIL %s: expectation for cycle %0d not checked in time", e.nm, e.cyc);
            end else if (act !== want) begin
                n_bad++;
                $display("FAIL %s (cyc %0d): tick/busy/done/count/tick_cnt got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d",
                         e.nm, cyc_cnt, act[18], act[17], act[16], act[15:8], act[7:0],
                         e.t, e.b, e.d, e.c, e.tc);
            end
        end
    end

    initial begin
        rst_n = 1'b0; clk2 = 1'b1;
        drv(0, 0, 8'd0, 0, 0, 0);
        step();
        // 1: reset with clk2 held high
        drv(0, 0, 8'd0, 0, 0, 0); e8("rst8", 0,0,0,0,0); e4("rst4", 0,0,0,0,0); step();
        rst_n = 1'b1;
        drv(0, 0, 8'd0, 0, 0, 0); e8("post_rst_a", 0,0,0,0,0); step();
        drv(0, 0, 8'd0, 0, 0, 0); e8("post_rst_b", 0,0,0,0,0); step();
        drv(0, 0, 8'd0, 0, 0, 0); e8("post_rst_c", 0,0,0,0,0); step();
        ph_on = 1'b1; ph = 0;

        // 2: load 3, no reload
        drv(1,0,8'd3,0,0,0); e8("t2_start", 0,0,0,0,0); step();
        drv(0,0,8'd0,0,0,0); e8("t2_busy",  0,1,0,3,0); step();
        drv(0,0,8'd0,0,0,0); e8("t2_tk1",   1,1,0,3,0); step();
        drv(0,0,8'd0,0,0,0); e8("t2_c2a",   0,1,0,2,1); step();
        drv(0,0,8'd0,0,0,0); e8("t2_c2b",   0,1,0,2,1); step();
        drv(0,0,8'd0,0,0,0); e8("t2_c2c",   0,1,0,2,1); step();
        drv(0,0,8'd0,0,0,0); e8("t2_tk2",   1,1,0,2,1); step();
        drv(0,0,8'd0,0,0,0); e8("t2_c1a",   0,1,0,1,2); step();
        drv(0,0,8'd0,0,0,0); e8("t2_c1b",   0,1,0,1,2); step();
        drv(0,0,8'd0,0,0,0); e8("t2_c1c",   0,1,0,1,2); step();
        drv(0,0,8'd0,0,0,0); e8("t2_tk3",   1,1,0,1,2); step();
        drv(0,0,8'd0,0,0,0); e8("t2_done",  0,0,1,0,3); step();
        drv(1,0,8'd7,0,0,0); e8("t2_dn_st", 0,0,1,0,3); step();
        drv(0,0,8'd0,0,0,0); e8("t2_dn_b",  0,0,1,0,3); step();
        drv(0,0,8'd0,0,0,0); e8("t2_dn_tk", 1,0,1,0,3); step();
        drv(0,0,8'd0,0,0,0); e8("t2_dn_c",  0,0,1,0,3); step();
        drv(0,0,8'd0,0,1,0); e8("t2_ack",   0,0,1,0,3); step();
        drv(0,0,8'd0,0,0,0); e8("t2_idle",  0,0,0,0,3); step();

        // 3: zero-length start (tick in IDLE not counted)
        drv(1,0,8'd0,0,0,0); e8("t3_start", 1,0,0,0,3); step();
        drv(0,0,8'd0,1,1,0); e8("t3_done",  0,0,1,0,3); step();
        drv(0,0,8'd0,0,0,0); e8("t3_idle",  0,0,0,0,3); step();

        // 4: load 2 with auto-reload; ack coincides with a tick
        drv(1,0,8'd2,1,0,0); e8("t4_start", 0,0,0,0,3); step();
        drv(0,0,8'd0,0,0,0); e8("t4_tk1",   1,1,0,2,3); step();
        drv(0,0,8'd0,0,0,0); e8("t4_c1a",   0,1,0,1,4); step();
        drv(0,0,8'd0,0,0,0); e8("t4_c1b",   0,1,0,1,4); step();
        drv(0,0,8'd0,0,0,0); e8("t4_c1c",   0,1,0,1,4); step();
        drv(0,0,8'd0,0,0,0); e8("t4_tk2",   1,1,0,1,4); step();
        drv(0,0,8'd0,0,0,0); e8("t4_done",  0,0,1,0,5); step();
        drv(0,0,8'd0,0,0,0); e8("t4_dn_b",  0,0,1,0,5); step();
        drv(0,0,8'd0,0,0,0); e8("t4_dn_c",  0,0,1,0,5); step();
        drv(0,0,8'd0,1,1,0); e8("t4_ack_tk",1,0,1,0,5); step();
        drv(0,0,8'd0,0,0,0); e8("t4_reload",0,1,0,2,5); step();
        idle_n(2);
        drv(0,0,8'd0,0,0,0); e8("t4_tk3",   1,1,0,2,5); step();
        drv(0,0,8'd0,0,0,0); e8("t4_c1d",   0,1,0,1,6); step();
        idle_n(2);
        drv(0,0,8'd0,0,0,0); e8("t4_tk4",   1,1,0,1,6); step();
        drv(0,0,8'd0,0,1,0); e8("t4_done2", 0,0,1,0,7); step();
        drv(0,0,8'd0,0,0,0); e8("t4_idle",  0,0,0,0,7); step();

        // 5: abort with coincident tick, then start+abort
        drv(1,0,8'd5,0,0,0); e8("t5_start", 0,0,0,0,7); step();
        drv(0,0,8'd0,0,0,1); e8("t5_abort", 1,1,0,5,7); step();
        drv(1,0,8'd4,0,0,1); e8("t5_ab_idl",0,0,0,0,7); step();
        drv(0,0,8'd0,0,0,0); e8("t5_st_ab", 0,0,0,0,7); step();

        // 6: 4-bit instance, 18 ticks across a reload -> tick_cnt wraps to 2
        drv(0,1,8'd9,1,0,0); e4("t6_start", 0,0,0,0,0); step();
        drv(0,0,8'd0,0,0,0); e4("t6_tk1",   1,1,0,9,0); step();
        drv(0,0,8'd0,0,0,0); e4("t6_c8",    0,1,0,8,1); step();
        idle_n(31);
        drv(0,0,8'd0,1,1,0); e4("t6_done1", 0,0,1,0,9); step();
        drv(0,0,8'd0,0,0,0); e4("t6_reload",0,1,0,9,9); step();
        idle_n(34);
        drv(0,0,8'd0,1,1,0); e4("t6_wrap",  0,0,1,0,2); step();
        drv(0,0,8'd0,0,0,0); e4("t6_run_a", 0,1,0,9,2); step();
        drv(0,0,8'd0,0,0,0); e4("t6_run_b", 0,1,0,9,2); step();
        drv(0,0,8'd0,0,0,0); e4("t6_tk",    1,1,0,9,2); step();
        rst_n = 1'b0;
        drv(0,0,8'd0,0,0,0); e4("t6_pre_rst",0,1,0,8,3); e8("t6_idle8",0,0,0,0,7); step();
        rst_n = 1'b1;
        drv(0,0,8'd0,0,0,0); e4("t6_rst4",  0,0,0,0,0); e8("t6_rst8",0,0,0,0,0); step();
        drv(0,0,8'd0,0,0,0); e4("t6_post",  0,0,0,0,0); step();

        idle_n(2);
        if (sb.size() > 0) begin
            $display("FAIL scoreboard_drain: %0d expectations left unchecked, want 0", sb.size());
            n_cmp += sb.size();
            n_bad += sb.size();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_clk2_tick_timer
`default_nettype wire
